// File: rtl/button_pkg.sv
// Shared types and timing helpers for the button_bank front end.
// Holds the channel FSM state enum, default timing constants and the tick divider.
package button_pkg;

  typedef enum logic [1:0] {
    ST_REL,
    ST_HELD,
    ST_LONG
  } btn_state_t;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_CLK_HZ      = 100_000_000;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_MS = 20;
  localparam int DEF_LONG_MS     = 1000;
  localparam int DEF_REPEAT_MS   = 200;

  // Clock cycles per 1 ms tick.
  function automatic int ms_tick_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, tick-based debounce, edge detect,
// and the release/held/long FSM that produces long_press and auto-repeat.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   tick          shared 1 ms strobe from the bank prescaler
//   noisy         raw asynchronous button input
//   repeat_en     auto-repeat enable while long-held
//   debounced     stable level
//   p_edge/n_edge 1-cycle pulses on debounced rise/fall
//   long_press    1-cycle pulse once per press after LONG_MS ticks
//   repeat_pulse  1-cycle pulse every REPEAT_MS ticks while long-held
//   press_evt     p_edge | repeat_pulse
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int LONG_MS     = DEF_LONG_MS,
  parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic noisy,
  input  logic repeat_en,
  output logic debounced,
  output logic p_edge,
  output logic n_edge,
  output logic long_press,
  output logic repeat_pulse,
  output logic press_evt
);

  localparam int DBW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW  = $clog2(LONG_MS + 1);
  localparam int RW  = $clog2(REPEAT_MS + 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_channel: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_MS < 1) begin : g_bad_db
    $error("button_channel: DEBOUNCE_MS must be >= 1");
  end
  if (LONG_MS < 1) begin : g_bad_long
    $error("button_channel: LONG_MS must be >= 1");
  end
  if (REPEAT_MS < 1) begin : g_bad_rep
    $error("button_channel: REPEAT_MS must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sy;

  logic           deb_q, deb_d;
  logic           deb_dly_q, deb_dly_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;

  btn_state_t    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          long_q, long_d;
  logic          rep_q, rep_d;

  // Synchroniser and debounce counter.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], noisy};
    sy       = sync_q[SYNC_STAGES-1];
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    if (sy == deb_q) begin
      db_cnt_d = '0;
    end else if (tick) begin
      if (db_cnt_q == DBW'(DEBOUNCE_MS - 1)) begin
        deb_d    = ~deb_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end
    deb_dly_d = deb_q;
  end

  // Edges are pure functions of registers, so they line up
  // with the first cycle of the new debounced level.
  assign p_edge = deb_q & ~deb_dly_q;
  assign n_edge = ~deb_q & deb_dly_q;

  // Press FSM. A release checked first means it beats any
  // threshold landing in the same cycle.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    long_d     = 1'b0;
    rep_d      = 1'b0;
    unique case (state_q)
      ST_REL: begin
        if (p_edge) begin
          state_d    = ST_HELD;
          hold_cnt_d = '0;
        end
      end
      ST_HELD: begin
        if (n_edge) begin
          state_d = ST_REL;
        end else if (tick) begin
          if (hold_cnt_q == HW'(LONG_MS - 1)) begin
            long_d    = 1'b1;
            state_d   = ST_LONG;
            rep_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
      end
      ST_LONG: begin
        if (n_edge) begin
          state_d = ST_REL;
        end else if (tick) begin
          if (rep_cnt_q == RW'(REPEAT_MS - 1)) begin
            rep_cnt_d = '0;
            rep_d     = repeat_en;
          end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
          end
        end
      end
      default: begin
        state_d = ST_REL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_dly_q  <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= ST_REL;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      long_q     <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_dly_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      long_q     <= long_d;
      rep_q      <= rep_d;
    end
  end

  assign debounced    = deb_q;
  assign long_press   = long_q;
  assign repeat_pulse = rep_q;
  assign press_evt    = p_edge | rep_q;

endmodule

// File: rtl/button_bank.sv
// N-channel button front end: shared 1 ms prescaler feeding N button_channel
// instances, plus the any_pressed summary.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   noisy         raw button inputs, one per channel
//   repeat_en     per-channel auto-repeat enable
//   debounced     stable levels
//   p_edge/n_edge debounced rise/fall pulses
//   long_press    long-hold pulse per channel
//   repeat_pulse  auto-repeat pulse per channel
//   press_evt     counter increment strobe (p_edge | repeat_pulse)
//   any_pressed   OR of all debounced levels
module button_bank
  import button_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int LONG_MS     = DEF_LONG_MS,
  parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] noisy,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] p_edge,
  output logic [N_CH-1:0] n_edge,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] repeat_pulse,
  output logic [N_CH-1:0] press_evt,
  output logic            any_pressed
);

  localparam int TICK_DIV = ms_tick_div(CLK_HZ);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (CLK_HZ < 1000 || (CLK_HZ % 1000) != 0) begin : g_bad_clk
    $error("button_bank: CLK_HZ must be a multiple of 1000 and >= 1000");
  end
  if (N_CH < 1) begin : g_bad_n
    $error("button_bank: N_CH must be >= 1");
  end

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  // Free-running 0..TICK_DIV-1; tick marks the last count.
  always_comb begin
    tick  = (pre_q == PW'(TICK_DIV - 1));
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .noisy        (noisy[i]),
      .repeat_en    (repeat_en[i]),
      .debounced    (debounced[i]),
      .p_edge       (p_edge[i]),
      .n_edge       (n_edge[i]),
      .long_press   (long_press[i]),
      .repeat_pulse (repeat_pulse[i]),
      .press_evt    (press_evt[i])
    );
  end

  assign any_pressed = |debounced;

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: directed presses queue expected pulses,
// a negedge monitor pops and checks every pulse the DUT emits.
module tb_button_bank;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] noisy = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] debounced, p_edge, n_edge;
  logic [N-1:0] long_press, repeat_pulse, press_evt;
  logic         any_pressed;

  button_bank #(
    .N_CH        (N),
    .CLK_HZ      (10_000),
    .SYNC_STAGES (2),
    .DEBOUNCE_MS (3),
    .LONG_MS     (10),
    .REPEAT_MS   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .noisy        (noisy),
    .repeat_en    (repeat_en),
    .debounced    (debounced),
    .p_edge       (p_edge),
    .n_edge       (n_edge),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .press_evt    (press_evt),
    .any_pressed  (any_pressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] mask;
    int           lo;
    int           hi;
  } ev_t;

  ev_t   exp_q [4][$];
  string kname [4] = '{"p_edge", "n_edge", "long_press", "repeat_pulse"};

  int cyc = 0;
  int base = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, got, want, cyc - base);
    end
  endtask

  task automatic exp_ev(int k, logic [N-1:0] m, int lo, int hi);
    ev_t e;
    e.mask = m;
    e.lo   = base + lo;
    e.hi   = base + hi;
    exp_q[k].push_back(e);
  endtask

  // Returns 1 ns after the posedge that brings cyc to base+rel.
  task automatic go(int rel);
    while (cyc < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(int rel);
    go(rel);
    @(negedge clk);
  endtask

  logic [N-1:0] mv;
  ev_t          me;

  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < 4; k++) begin
        unique case (k)
          0:       mv = p_edge;
          1:       mv = n_edge;
          2:       mv = long_press;
          default: mv = repeat_pulse;
        endcase
        if (mv != '0) begin
          n_chk++;
          if (exp_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected: got %b at cycle %0d, none expected",
                     kname[k], mv, cyc - base);
          end else begin
            me = exp_q[k].pop_front();
            if (me.mask !== mv || cyc < me.lo || cyc > me.hi) begin
              n_fail++;
              $display("FAIL %s: got %b at cycle %0d, want %b in %0d..%0d",
                       kname[k], mv, cyc - base, me.mask,
                       me.lo - base, me.hi - base);
            end
          end
        end
      end
      if ((p_edge | repeat_pulse | press_evt) != '0)
        chk("press_evt", 32'(press_evt), 32'(p_edge | repeat_pulse));
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    base   = cyc;
    mon_on = 1'b1;

    @(negedge clk);
    chk("rst debounced", 32'(debounced), 0);
    chk("rst p_edge", 32'(p_edge), 0);
    chk("rst n_edge", 32'(n_edge), 0);
    chk("rst long_press", 32'(long_press), 0);
    chk("rst repeat_pulse", 32'(repeat_pulse), 0);
    chk("rst press_evt", 32'(press_evt), 0);
    chk("rst any_pressed", 32'(any_pressed), 0);

    // 1: bouncing ch0, then a clean rise at 209 and release at 269.
    exp_ev(0, 2'b01, 209, 241);
    exp_ev(1, 2'b01, 300, 311);
    for (int k = 0; k < 14; k++) begin
      go(1 + 15 * k);
      noisy[0] = (k % 2 == 0);
    end
    sample(200);
    chk("bounce debounced", 32'(debounced), 0);
    go(209);
    noisy[0] = 1'b1;
    sample(241);
    chk("t1 debounced", 32'(debounced), 32'b01);
    go(269);
    noisy[0] = 1'b0;

    // 2+3: press with repeat: long 100 after p_edge, repeats every 40.
    exp_ev(0, 2'b01, 540, 551);
    exp_ev(2, 2'b01, 640, 640);
    for (int r = 0; r < 4; r++) exp_ev(3, 2'b01, 680 + 40 * r, 680 + 40 * r);
    exp_ev(1, 2'b01, 830, 841);
    go(509);
    noisy[0]     = 1'b1;
    repeat_en[0] = 1'b1;
    sample(545);
    chk("t2 any_pressed", 32'(any_pressed), 1);
    chk("t2 debounced", 32'(debounced), 32'b01);
    go(799);
    noisy[0] = 1'b0;

    // 4: long hold without repeat.
    exp_ev(0, 2'b01, 1040, 1051);
    exp_ev(2, 2'b01, 1140, 1140);
    exp_ev(1, 2'b01, 1340, 1351);
    go(1009);
    repeat_en[0] = 1'b0;
    noisy[0]     = 1'b1;
    go(1309);
    noisy[0] = 1'b0;
    sample(1345);
    chk("t4 any_pressed", 32'(any_pressed), 0);

    // 6: both channels together, ch1 released mid-repeat.
    exp_ev(0, 2'b11, 1540, 1551);
    exp_ev(2, 2'b11, 1640, 1640);
    exp_ev(3, 2'b01, 1680, 1680);
    exp_ev(1, 2'b10, 1720, 1731);
    for (int r = 1; r < 4; r++) exp_ev(3, 2'b01, 1680 + 40 * r, 1680 + 40 * r);
    go(1509);
    repeat_en = 2'b01;
    noisy     = 2'b11;
    sample(1545);
    chk("t6 debounced", 32'(debounced), 32'b11);
    go(1689);
    noisy[1] = 1'b0;
    sample(1725);
    chk("t6 ch0 held", 32'(debounced), 32'b01);

    // 5: one-cycle reset while ch0 is long-held.
    exp_ev(0, 2'b01, 1840, 1851);
    exp_ev(2, 2'b01, 1940, 1940);
    exp_ev(1, 2'b01, 1970, 1981);
    go(1809);
    reset = 1'b1;
    go(1810);
    reset = 1'b0;
    @(negedge clk);
    chk("t5 debounced", 32'(debounced), 0);
    chk("t5 long_press", 32'(long_press), 0);
    chk("t5 repeat_pulse", 32'(repeat_pulse), 0);
    chk("t5 press_evt", 32'(press_evt), 0);
    chk("t5 any_pressed", 32'(any_pressed), 0);
    go(1939);
    noisy[0] = 1'b0;

    go(2000);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL %s missing: got %0d outstanding, want 0",
                 kname[k], exp_q[k].size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
